// File: rtl/fft_pkg.sv
// Shared FFT types: complex sample, per-stage info, loader state enum, bit-reverse helper.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package fft_pkg;

    localparam int CPLX_W = 16;

    typedef struct packed {
        logic signed [CPLX_W-1:0] re;
        logic signed [CPLX_W-1:0] im;
    } complex_t;

    typedef struct packed {
        logic [3:0] stage;
        logic [7:0] twiddle_stride;
        logic       last_stage;
    } stage_info_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FIRE = 2'd2,
        RUN  = 2'd3
    } loader_state_t;

    // Reverse the low 'width' bits of idx; bits above width come back as zero.
    function automatic logic [15:0] bitrev(input logic [15:0] idx, input int width);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            if (i < width) begin
                r[width-1-i] = idx[i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_bitrev_addr.sv
// Bit-reversed address generator for loading a decimation-in-time FFT bank.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; output follows input every cycle.
module fft_bitrev_addr
    import fft_pkg::*;
#(
    parameter int W = 3
) (
    input  logic [W-1:0] i_addr,
    output logic [W-1:0] o_addr
);

    assign o_addr = W'(bitrev(16'(i_addr), W));

endmodule

// File: rtl/fft_sample_loader.sv
// Streams one N-point complex frame into FFT bank 0, then pulses fft_start; address order is
// bit-reversed when FFT_LOADER_BITREV_EN is defined, natural otherwise.
// Latency: 1 cycle from accepted sample to bank write. Backpressure: in_ready only in LOAD (low in FIRE/RUN).
module fft_sample_loader
    import fft_pkg::*;
#(
    parameter int  N          = 8,
    parameter int  DATA_WIDTH = 16,
    localparam int AW         = $clog2(N)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in_re,
    input  logic [DATA_WIDTH-1:0]   in_im,
    input  logic                    in_last,
    output logic                    wr_en,
    output logic [AW-1:0]           wr_addr,
    output logic [2*DATA_WIDTH-1:0] wr_data,
    output logic                    fft_start,
    input  logic                    fft_finish,
    output logic                    frame_err,
    output logic [15:0]             frame_cnt
);

    loader_state_t           r_state;
    loader_state_t           w_state_nxt;
    logic [AW-1:0]           r_count;
    logic                    r_wr_en;
    logic [AW-1:0]           r_wr_addr;
    logic [2*DATA_WIDTH-1:0] r_wr_data;
    logic                    r_fft_start;
    logic                    r_frame_err;
    logic [15:0]             r_frame_cnt;

    logic                    w_accept;
    logic                    w_last_slot;
    logic                    w_early_last;
    logic [AW-1:0]           w_map_addr;

    assign in_ready     = (r_state == LOAD);
    assign w_accept     = in_valid & in_ready;
    assign w_last_slot  = (r_count == AW'(N-1));
    assign w_early_last = in_last & ~w_last_slot;

`ifdef FFT_LOADER_BITREV_EN
    fft_bitrev_addr #(.W(AW)) u_bitrev (
        .i_addr (r_count),
        .o_addr (w_map_addr)
    );
`else
    assign w_map_addr = r_count;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode: a frame launches only once the final slot has been accepted.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = LOAD;
            LOAD:    if (w_accept && w_last_slot) w_state_nxt = FIRE;
            FIRE:    w_state_nxt = RUN;
            RUN:     if (fft_finish) w_state_nxt = LOAD;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Write port, slot counter, start/error pulses and completed-frame counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count     <= '0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_fft_start <= 1'b0;
            r_frame_err <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_wr_en     <= w_accept;
            // Start lines up with the final write so RAM commit and core launch share an edge.
            r_fft_start <= w_accept & w_last_slot;
            // Error on in_last arriving early, or missing on the final slot.
            r_frame_err <= w_accept & (in_last ^ w_last_slot);
            if (w_accept) begin
                r_wr_addr <= w_map_addr;
                r_wr_data <= {in_re, in_im};
                // Early in_last abandons the partial frame; the counter otherwise wraps at N.
                r_count   <= w_early_last ? '0 : r_count + AW'(1);
            end
            if (r_state == RUN && fft_finish) begin
                r_count     <= '0;
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

    assign wr_en     = r_wr_en;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign fft_start = r_fft_start;
    assign frame_err = r_frame_err;
    assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_fft_sample_loader.sv
// Bench for fft_sample_loader (N=8, DATA_WIDTH=16): directed frames, scoreboard of expected writes.
// Latency: n/a. Backpressure: stimulus waits on in_ready with a bounded cycle budget.
// Expected write addresses follow FFT_LOADER_BITREV_EN the same way the design does.
module tb_fft_sample_loader;

    typedef struct {
        logic [2:0]  addr;
        logic [31:0] data;
        logic        start;
        logic        err;
    } exp_t;

`ifdef FFT_LOADER_BITREV_EN
    localparam logic [2:0] ADDR_TBL [8] = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};
`else
    localparam logic [2:0] ADDR_TBL [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_re;
    logic [15:0] in_im;
    logic        in_last;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [31:0] wr_data;
    logic        fft_start;
    logic        fft_finish;
    logic        frame_err;
    logic [15:0] frame_cnt;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fft_sample_loader #(.N(8), .DATA_WIDTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_re      (in_re),
        .in_im      (in_im),
        .in_last    (in_last),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .fft_start  (fft_start),
        .fft_finish (fft_finish),
        .frame_err  (frame_err),
        .frame_cnt  (frame_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write must match the head of the scoreboard; start/err never pulse alone.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (wr_en === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", {29'd0, wr_addr}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr",   {29'd0, wr_addr},   {29'd0, e.addr});
                    chk("wr_data",   wr_data,            e.data);
                    chk("fft_start", {31'd0, fft_start}, {31'd0, e.start});
                    chk("frame_err", {31'd0, frame_err}, {31'd0, e.err});
                end
            end else begin
                chk("idle_pulses", {30'd0, fft_start, frame_err}, 32'd0);
            end
        end
    end

    // Offer sample k until accepted; push its expected write (slot -> address table).
    task automatic send(input int k, input bit last, input int slot, input bit st, input bit er);
        int   w;
        exp_t e;
        logic [15:0] re;
        logic [15:0] im;
        re = 16'(k);
        im = 16'(-k);
        @(negedge clk);
        in_valid = 1'b1;
        in_re    = re;
        in_im    = im;
        in_last  = last;
        w = 0;
        while (in_ready !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (in_ready !== 1'b1) begin
            chk("accept_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
        end else begin
            e.addr  = ADDR_TBL[slot];
            e.data  = {re, im};
            e.start = st;
            e.err   = er;
            exp_q.push_back(e);
        end
    endtask

    task automatic idle1();
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Called right after the final sample: FIRE, RUN hold-off, then completion from the core.
    task automatic finish_run(input int exp_cnt);
        idle1();
        chk("ready_in_fire", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        chk("ready_in_run", {31'd0, in_ready}, 32'd0);
        repeat (2) @(negedge clk);
        chk("ready_run_hold", {31'd0, in_ready}, 32'd0);
        fft_finish = 1'b1;
        @(negedge clk);
        fft_finish = 1'b0;
        chk("ready_after_finish", {31'd0, in_ready}, 32'd1);
        chk("frame_cnt", {16'd0, frame_cnt}, exp_cnt);
    endtask

    task automatic full_frame(input int base);
        for (int k = 0; k < 8; k++) begin
            send(base + k, k == 7, k, k == 7, 1'b0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        rst      = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
        chk("rst_wr_en",     {31'd0, wr_en},     32'd0);
        chk("rst_wr_addr",   {29'd0, wr_addr},   32'd0);
        chk("rst_wr_data",   wr_data,            32'd0);
        chk("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("ready_after_rst", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_re      = '0;
        in_im      = '0;
        in_last    = 1'b0;
        fft_finish = 1'b0;

        // 1. Reset state and release.
        do_reset();

        // 2. Nominal back-to-back frame.
        full_frame(0);
        finish_run(1);

        // 3. Valid on alternate cycles.
        for (int k = 0; k < 8; k++) begin
            send(16 + k, k == 7, k, k == 7, 1'b0);
            if (k < 7) idle1();
        end
        finish_run(2);

        // 4. in_last on the 5th sample, then a clean frame from slot 0.
        for (int k = 0; k < 5; k++) begin
            send(32 + k, k == 4, k, 1'b0, k == 4);
        end
        full_frame(48);
        finish_run(3);

        // 5. Finish outside RUN is ignored; three runs after reset count to 3.
        do_reset();
        fft_finish = 1'b1;
        @(negedge clk);
        fft_finish = 1'b0;
        @(negedge clk);
        chk("finish_in_load_ready", {31'd0, in_ready},  32'd1);
        chk("finish_in_load_cnt",   {16'd0, frame_cnt}, 32'd0);
        for (int r = 0; r < 3; r++) begin
            full_frame(64 + 8 * r);
            finish_run(r + 1);
        end

        // 6. Reset after 3 samples drops the frame; next frame starts at slot 0.
        for (int k = 0; k < 3; k++) begin
            send(100 + k, 1'b0, k, 1'b0, 1'b0);
        end
        idle1();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("midrst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        chk("midrst_in_ready",  {31'd0, in_ready},  32'd0);
        rst = 1'b0;
        full_frame(110);
        finish_run(1);

        // 7. in_last missing on the final sample: launched, with an error pulse.
        for (int k = 0; k < 8; k++) begin
            send(120 + k, 1'b0, k, k == 7, k == 7);
        end
        finish_run(2);

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
